// File: rtl/apb_master_mc.sv
// APB4 master bridging a valid/ready host port to NSLV slaves with address decode, strobes and error reporting.
// Define APB_TIMEOUT_EN to abort ACCESS phases that exceed TO_CYC not-ready cycles.
module apb_master_mc #(
   parameter int DW     = 32,
   parameter int AW     = 8,
   parameter int NSLV   = 4,
   parameter int TO_CYC = 16
) (
   input  logic                 clk_APB,
   input  logic                 rst,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic                 req_write,
   input  logic [AW-1:0]        req_addr,
   input  logic [DW-1:0]        req_wdata,
   input  logic [DW/8-1:0]      req_strb,
   output logic                 rsp_valid,
   output logic [DW-1:0]        rsp_rdata,
   output logic                 rsp_err,
   output logic [NSLV-1:0]      PSEL,
   output logic                 PENABLE,
   output logic                 PWRITE,
   output logic [AW-1:0]        PADDR,
   output logic [DW-1:0]        PWDATA,
   output logic [DW/8-1:0]      PSTRB,
   input  logic [NSLV-1:0]      PREADY,
   input  logic [NSLV*DW-1:0]   PRDATA,
   input  logic [NSLV-1:0]      PSLVERR
);

   localparam int SW = $clog2(NSLV);
   localparam logic [SW:0] NSLV_C = NSLV[SW:0];

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

   state_t        state_q, state_d;
   logic [SW-1:0] idx_q;
   logic [SW-1:0] req_idx;
   logic          dec_ok;
   logic          accept;
   logic          done;
   logic          abort;
   logic          sel_ready;
   logic          sel_err;
   logic [DW-1:0] sel_rdata;

   assign req_idx = req_addr[AW-1 -: SW];
   assign dec_ok  = ({1'b0, req_idx} < NSLV_C);

   // Only the addressed slave's handshake and data are looked at.
   always_comb begin
      sel_ready = 1'b0;
      sel_err   = 1'b0;
      sel_rdata = '0;
      for (int i = 0; i < NSLV; i++) begin
         if (idx_q == SW'(i)) begin
            sel_ready = PREADY[i];
            sel_err   = PSLVERR[i];
            sel_rdata = PRDATA[i*DW +: DW];
         end
      end
   end

`ifdef APB_TIMEOUT_EN
   localparam logic [15:0] TO_LIM = 16'(TO_CYC - 1);
   logic [15:0] to_cnt_q;

   always_ff @(posedge clk_APB or negedge rst) begin
      if (!rst) begin
         to_cnt_q <= '0;
      end else if (state_q == SETUP) begin
         to_cnt_q <= '0;
      end else if (state_q == ACCESS && !sel_ready) begin
         to_cnt_q <= to_cnt_q + 16'd1;
      end
   end

   // A PREADY arriving on the limit edge still completes normally.
   assign abort = (state_q == ACCESS) && !sel_ready && (to_cnt_q == TO_LIM);
`else
   // Timeout compiled out: TO_CYC has no effect, the comparison is constant false.
   assign abort = (TO_CYC < 0);
`endif

   always_ff @(posedge clk_APB or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      accept    = 1'b0;
      done      = 1'b0;
      req_ready = (state_q == IDLE);
      PENABLE   = (state_q == ACCESS);
      PSEL      = '0;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               accept = 1'b1;
               if (dec_ok) state_d = SETUP;
            end
         end
         SETUP: begin
            PSEL    = NSLV'(1) << idx_q;
            state_d = ACCESS;
         end
         ACCESS: begin
            PSEL = NSLV'(1) << idx_q;
            if (sel_ready) begin
               done    = 1'b1;
               state_d = IDLE;
            end else if (abort) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Bus fields load only for decodable requests, so they hold their last real transfer in IDLE.
   always_ff @(posedge clk_APB or negedge rst) begin
      if (!rst) begin
         idx_q     <= '0;
         PWRITE    <= 1'b0;
         PADDR     <= '0;
         PWDATA    <= '0;
         PSTRB     <= '0;
         rsp_valid <= 1'b0;
         rsp_err   <= 1'b0;
         rsp_rdata <= '0;
      end else begin
         rsp_valid <= 1'b0;
         rsp_err   <= 1'b0;
         rsp_rdata <= '0;
         if (accept) begin
            if (dec_ok) begin
               idx_q  <= req_idx;
               PWRITE <= req_write;
               PADDR  <= req_addr;
               PWDATA <= req_wdata;
               PSTRB  <= req_write ? req_strb : '0;
            end else begin
               rsp_valid <= 1'b1;
               rsp_err   <= 1'b1;
            end
         end
         if (done) begin
            rsp_valid <= 1'b1;
            rsp_err   <= sel_err;
            rsp_rdata <= (!PWRITE && !sel_err) ? sel_rdata : '0;
         end else if (abort) begin
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_apb_master_mc.sv
// Directed bench for apb_master_mc: vector table of full transfers plus reset, decode-error and timeout sequences.
module tb_apb_master_mc;

   localparam int TB_TO = 4;

   logic         clk_APB;
   logic         rst;

   logic         req_valid, req_ready, req_write;
   logic [7:0]   req_addr;
   logic [31:0]  req_wdata;
   logic [3:0]   req_strb;
   logic         rsp_valid, rsp_err;
   logic [31:0]  rsp_rdata;
   logic [3:0]   PSEL;
   logic         PENABLE, PWRITE;
   logic [7:0]   PADDR;
   logic [31:0]  PWDATA;
   logic [3:0]   PSTRB;
   logic [3:0]   PREADY;
   logic [127:0] PRDATA;
   logic [3:0]   PSLVERR;

   logic         b_req_valid, b_req_ready, b_req_write;
   logic [7:0]   b_req_addr;
   logic [31:0]  b_req_wdata;
   logic [3:0]   b_req_strb;
   logic         b_rsp_valid, b_rsp_err;
   logic [31:0]  b_rsp_rdata;
   logic [2:0]   b_PSEL;
   logic         b_PENABLE, b_PWRITE;
   logic [7:0]   b_PADDR;
   logic [31:0]  b_PWDATA;
   logic [3:0]   b_PSTRB;
   logic [2:0]   b_PREADY;
   logic [95:0]  b_PRDATA;
   logic [2:0]   b_PSLVERR;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic        write;
      logic [7:0]  addr;
      logic [31:0] wdata;
      logic [3:0]  strb;
      int          waits;
      logic        slverr;
      logic [31:0] rdata;
      logic [3:0]  exp_psel;
      logic [3:0]  exp_pstrb;
      logic        exp_err;
      logic [31:0] exp_rdata;
   } vec_t;

   vec_t vecs [6];

   apb_master_mc #(.DW(32), .AW(8), .NSLV(4), .TO_CYC(TB_TO)) dut (
      .clk_APB(clk_APB), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
      .PWDATA(PWDATA), .PSTRB(PSTRB), .PREADY(PREADY), .PRDATA(PRDATA),
      .PSLVERR(PSLVERR)
   );

   apb_master_mc #(.DW(32), .AW(8), .NSLV(3), .TO_CYC(TB_TO)) dut3 (
      .clk_APB(clk_APB), .rst(rst),
      .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(b_req_write),
      .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_strb(b_req_strb),
      .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err),
      .PSEL(b_PSEL), .PENABLE(b_PENABLE), .PWRITE(b_PWRITE), .PADDR(b_PADDR),
      .PWDATA(b_PWDATA), .PSTRB(b_PSTRB), .PREADY(b_PREADY), .PRDATA(b_PRDATA),
      .PSLVERR(b_PSLVERR)
   );

   initial clk_APB = 1'b0;
   always #5 clk_APB = ~clk_APB;

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk_APB);
      #1;
   endtask

   // Runs one transfer from the accept cycle to the response cycle; unselected slaves are driven ready and erroring.
   task automatic apply_stimulus(input vec_t v);
      int slot;
      slot = 0;
      for (int i = 0; i < 4; i++) if (v.exp_psel[i]) slot = i;
      check_output("ready_idle", req_ready, 1);
      req_valid = 1'b1;
      req_write = v.write;
      req_addr  = v.addr;
      req_wdata = v.wdata;
      req_strb  = v.strb;
      PREADY    = ~v.exp_psel;
      PSLVERR   = ~v.exp_psel;
      for (int i = 0; i < 4; i++) PRDATA[i*32 +: 32] = (i == slot) ? v.rdata : (32'hBAD0_0000 | 32'(i));
      next_cycle();
      req_valid = 1'b0;
      req_addr  = ~v.addr;
      req_wdata = ~v.wdata;
      req_strb  = ~v.strb;
      check_output("setup_psel", PSEL, v.exp_psel);
      check_output("setup_penable", PENABLE, 0);
      check_output("setup_paddr", PADDR, v.addr);
      check_output("setup_pwrite", PWRITE, v.write);
      check_output("setup_pwdata", PWDATA, v.wdata);
      check_output("setup_pstrb", PSTRB, v.exp_pstrb);
      check_output("setup_rsp_valid", rsp_valid, 0);
      for (int k = 0; k <= v.waits; k++) begin
         next_cycle();
         check_output("access_psel", PSEL, v.exp_psel);
         check_output("access_penable", PENABLE, 1);
         check_output("access_paddr", PADDR, v.addr);
         check_output("access_pstrb", PSTRB, v.exp_pstrb);
         check_output("access_rsp_valid", rsp_valid, 0);
         PREADY[slot]  = (k == v.waits);
         PSLVERR[slot] = (k == v.waits) && v.slverr;
      end
      next_cycle();
      PREADY[slot]  = 1'b0;
      PSLVERR[slot] = 1'b0;
      check_output("rsp_valid", rsp_valid, 1);
      check_output("rsp_err", rsp_err, v.exp_err);
      check_output("rsp_rdata", rsp_rdata, v.exp_rdata);
      check_output("rsp_psel", PSEL, 0);
      check_output("rsp_penable", PENABLE, 0);
      check_output("rsp_paddr_hold", PADDR, v.addr);
   endtask

   initial begin
`ifndef APB_TIMEOUT_EN
      int seen;
`endif
      vecs[0] = '{1'b1, 8'h45, 32'hDEAD_BEEF, 4'hF, 0, 1'b0, 32'h0000_0000, 4'b0010, 4'hF, 1'b0, 32'h0000_0000};
      vecs[1] = '{1'b0, 8'hC0, 32'h0000_0000, 4'hF, 3, 1'b0, 32'h1234_5678, 4'b1000, 4'h0, 1'b0, 32'h1234_5678};
      vecs[2] = '{1'b0, 8'h10, 32'h0000_0000, 4'h0, 1, 1'b1, 32'hAAAA_5555, 4'b0001, 4'h0, 1'b1, 32'h0000_0000};
      vecs[3] = '{1'b1, 8'h8C, 32'h0BAD_F00D, 4'h5, 2, 1'b1, 32'h1111_2222, 4'b0100, 4'h5, 1'b1, 32'h0000_0000};
      vecs[4] = '{1'b0, 8'h7F, 32'h0000_0000, 4'hA, 0, 1'b0, 32'hCAFE_F00D, 4'b0010, 4'h0, 1'b0, 32'hCAFE_F00D};
      vecs[5] = '{1'b1, 8'h3C, 32'h5A5A_5A5A, 4'h3, 0, 1'b0, 32'hFFFF_0000, 4'b0001, 4'h3, 1'b0, 32'h0000_0000};

      rst       = 1'b0;
      req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_strb = '0;
      PREADY    = '0;   PSLVERR = '0;     PRDATA = '0;
      b_req_valid = 1'b0; b_req_write = 1'b0; b_req_addr = '0; b_req_wdata = '0; b_req_strb = '0;
      b_PREADY  = 3'b111; b_PSLVERR = '0; b_PRDATA = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111};

      #1;
      check_output("reset_req_ready", req_ready, 1);
      check_output("reset_psel", PSEL, 0);
      check_output("reset_penable", PENABLE, 0);
      check_output("reset_paddr", PADDR, 0);
      check_output("reset_rsp_valid", rsp_valid, 0);
      check_output("reset_rsp_err", rsp_err, 0);
      next_cycle();
      next_cycle();
      rst = 1'b1;
      next_cycle();

      // Table transfers run back-to-back: each new request is accepted in the previous response cycle.
      for (int n = 0; n < 6; n++) apply_stimulus(vecs[n]);

      // Slave 1 never becomes ready.
      PREADY = '0; PSLVERR = '0; PRDATA = '0;
      req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h40;
      next_cycle();
      req_valid = 1'b0;
      check_output("to_setup_psel", PSEL, 4'b0010);
`ifdef APB_TIMEOUT_EN
      for (int k = 0; k < TB_TO; k++) begin
         next_cycle();
         check_output("to_access_penable", PENABLE, 1);
         check_output("to_access_rsp_valid", rsp_valid, 0);
      end
      next_cycle();
      check_output("to_rsp_valid", rsp_valid, 1);
      check_output("to_rsp_err", rsp_err, 1);
      check_output("to_rsp_rdata", rsp_rdata, 0);
      check_output("to_psel", PSEL, 0);
`else
      seen = 0;
      for (int k = 0; k < 100; k++) begin
         next_cycle();
         if (rsp_valid) seen++;
      end
      check_output("no_timeout_rsp", seen, 0);
      check_output("no_timeout_penable", PENABLE, 1);
      check_output("no_timeout_psel", PSEL, 4'b0010);
      PREADY[1] = 1'b1;
      PRDATA[32 +: 32] = 32'h0F0F_0F0F;
      next_cycle();
      PREADY = '0;
      check_output("late_rsp_valid", rsp_valid, 1);
      check_output("late_rsp_err", rsp_err, 0);
      check_output("late_rsp_rdata", rsp_rdata, 32'h0F0F_0F0F);
`endif
      next_cycle();

      // Reset asserted between edges during the second ACCESS cycle.
      req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h45; req_wdata = 32'hDEAD_BEEF; req_strb = 4'hF;
      next_cycle();
      req_valid = 1'b0;
      next_cycle();
      next_cycle();
      check_output("rst_pre_penable", PENABLE, 1);
      #2;
      rst = 1'b0;
      #1;
      check_output("rst_async_psel", PSEL, 0);
      check_output("rst_async_penable", PENABLE, 0);
      check_output("rst_async_paddr", PADDR, 0);
      check_output("rst_async_pwdata", PWDATA, 0);
      check_output("rst_async_pstrb", PSTRB, 0);
      check_output("rst_async_rsp_valid", rsp_valid, 0);
      check_output("rst_async_req_ready", req_ready, 1);
      PREADY[1] = 1'b1;
      next_cycle();
      next_cycle();
      rst = 1'b1;
      next_cycle();
      check_output("rst_after_rsp_valid", rsp_valid, 0);
      check_output("rst_after_psel", PSEL, 0);
      PREADY = '0;
      apply_stimulus(vecs[0]);
      next_cycle();

      // Three-slave instance: index 3 does not decode.
      b_req_valid = 1'b1; b_req_write = 1'b0; b_req_addr = 8'hC0;
      next_cycle();
      b_req_valid = 1'b0;
      check_output("dec_psel", b_PSEL, 0);
      check_output("dec_penable", b_PENABLE, 0);
      check_output("dec_rsp_valid", b_rsp_valid, 1);
      check_output("dec_rsp_err", b_rsp_err, 1);
      check_output("dec_rsp_rdata", b_rsp_rdata, 0);
      check_output("dec_req_ready", b_req_ready, 1);
      next_cycle();
      check_output("dec_rsp_once", b_rsp_valid, 0);
      b_req_valid = 1'b1; b_req_write = 1'b0; b_req_addr = 8'h80;
      next_cycle();
      b_req_valid = 1'b0;
      check_output("dec_ok_psel", b_PSEL, 3'b100);
      next_cycle();
      check_output("dec_ok_penable", b_PENABLE, 1);
      next_cycle();
      check_output("dec_ok_rsp_valid", b_rsp_valid, 1);
      check_output("dec_ok_rsp_err", b_rsp_err, 0);
      check_output("dec_ok_rsp_rdata", b_rsp_rdata, 32'h3333_3333);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
